// File: rtl/valve_seq_ctrl.sv
// Multi-channel sensor-driven valve sequencer: each channel independently runs
// open / wait / purge / cool with programmable durations, retrigger limit and fault latch.
module valve_seq_ctrl #(
  parameter int CHANNELS     = 4,
  parameter int ON_CYCLES    = 3,
  parameter int WAIT_CYCLES  = 4,
  parameter int PURGE_CYCLES = 2,
  parameter int COOL_CYCLES  = 5,
  parameter int MAX_RETRIG   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] sensor,
  input  logic [CHANNELS-1:0] fault_clr,
  output logic [CHANNELS-1:0] valve,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] fault
);

  localparam int MAX_A   = (ON_CYCLES > WAIT_CYCLES) ? ON_CYCLES : WAIT_CYCLES;
  localparam int MAX_B   = (PURGE_CYCLES > COOL_CYCLES) ? PURGE_CYCLES : COOL_CYCLES;
  localparam int MAX_DUR = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW      = (MAX_DUR < 1) ? 1 : $clog2(MAX_DUR + 1);
  localparam int RW      = (MAX_RETRIG < 1) ? 1 : $clog2(MAX_RETRIG + 1);

  localparam logic [TW-1:0] ON_LD    = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LD  = TW'(WAIT_CYCLES - 1);
  localparam logic [TW-1:0] PURGE_LD = TW'(PURGE_CYCLES - 1);
  localparam logic [TW-1:0] COOL_LD  = TW'(COOL_CYCLES - 1);
  localparam logic [RW-1:0] RT_MAX   = RW'(MAX_RETRIG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OPEN  = 3'd1,
    S_WAIT  = 3'd2,
    S_PURGE = 3'd3,
    S_COOL  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t        state_q  [CHANNELS];
  state_t        state_d  [CHANNELS];
  logic [TW-1:0] timer_q  [CHANNELS];
  logic [TW-1:0] timer_d  [CHANNELS];
  logic [RW-1:0] retrig_q [CHANNELS];
  logic [RW-1:0] retrig_d [CHANNELS];

  logic [CHANNELS-1:0] valve_q, valve_d;
  logic [CHANNELS-1:0] busy_q,  busy_d;
  logic [CHANNELS-1:0] fault_q, fault_d;

  always_comb begin
    valve_d = '0;
    busy_d  = '0;
    fault_d = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      state_d[ch]  = state_q[ch];
      timer_d[ch]  = timer_q[ch];
      retrig_d[ch] = retrig_q[ch];

      // FAULT ignores en; everywhere else en=0 aborts ahead of any sensor hit.
      if (state_q[ch] == S_FAULT) begin
        if (fault_clr[ch]) begin
          state_d[ch]  = S_IDLE;
          timer_d[ch]  = '0;
          retrig_d[ch] = '0;
        end
      end else if (!en[ch]) begin
        state_d[ch]  = S_IDLE;
        timer_d[ch]  = '0;
        retrig_d[ch] = '0;
      end else begin
        case (state_q[ch])
          S_IDLE: begin
            if (sensor[ch]) begin
              state_d[ch]  = S_OPEN;
              timer_d[ch]  = ON_LD;
              retrig_d[ch] = '0;
            end
          end
          S_OPEN: begin
            if (timer_q[ch] == '0) begin
              state_d[ch] = S_WAIT;
              timer_d[ch] = WAIT_LD;
            end else begin
              timer_d[ch] = timer_q[ch] - TW'(1);
            end
          end
          S_WAIT: begin
            if (sensor[ch]) begin
              if (retrig_q[ch] < RT_MAX) begin
                state_d[ch]  = S_OPEN;
                timer_d[ch]  = ON_LD;
                retrig_d[ch] = retrig_q[ch] + RW'(1);
              end else begin
                state_d[ch] = S_FAULT;
                timer_d[ch] = '0;
              end
            end else if (timer_q[ch] == '0) begin
              state_d[ch] = S_PURGE;
              timer_d[ch] = PURGE_LD;
            end else begin
              timer_d[ch] = timer_q[ch] - TW'(1);
            end
          end
          S_PURGE: begin
            if (sensor[ch]) begin
              state_d[ch] = S_WAIT;
              timer_d[ch] = WAIT_LD;
            end else if (timer_q[ch] == '0) begin
              state_d[ch] = S_COOL;
              timer_d[ch] = COOL_LD;
            end else begin
              timer_d[ch] = timer_q[ch] - TW'(1);
            end
          end
          S_COOL: begin
            if (timer_q[ch] == '0) begin
              state_d[ch]  = S_IDLE;
              timer_d[ch]  = '0;
              retrig_d[ch] = '0;
            end else begin
              timer_d[ch] = timer_q[ch] - TW'(1);
            end
          end
          default: begin
            state_d[ch]  = S_IDLE;
            timer_d[ch]  = '0;
            retrig_d[ch] = '0;
          end
        endcase
      end

      // Outputs are decoded from the next state so they register alongside it.
      valve_d[ch] = (state_d[ch] == S_OPEN) || (state_d[ch] == S_PURGE);
      busy_d[ch]  = (state_d[ch] != S_IDLE);
      fault_d[ch] = (state_d[ch] == S_FAULT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch]  <= S_IDLE;
        timer_q[ch]  <= '0;
        retrig_q[ch] <= '0;
      end
      valve_q <= '0;
      busy_q  <= '0;
      fault_q <= '0;
    end else begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch]  <= state_d[ch];
        timer_q[ch]  <= timer_d[ch];
        retrig_q[ch] <= retrig_d[ch];
      end
      valve_q <= valve_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign valve = valve_q;
  assign busy  = busy_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_valve_seq_ctrl.sv
// Self-checking bench for valve_seq_ctrl: vector table, hand-written corner
// sequences and randomized traffic against a phase/elapsed-time reference model.
module tb_valve_seq_ctrl;

  localparam int CH    = 4;
  localparam int ON    = 3;
  localparam int WT    = 4;
  localparam int PG    = 2;
  localparam int CL    = 5;
  localparam int MAXRT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] en = '0, sensor = '0, fault_clr = '0;
  logic [CH-1:0] valve, busy, fault;

  int n_cmp = 0;
  int n_bad = 0;

  valve_seq_ctrl #(
    .CHANNELS(CH), .ON_CYCLES(ON), .WAIT_CYCLES(WT),
    .PURGE_CYCLES(PG), .COOL_CYCLES(CL), .MAX_RETRIG(MAXRT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sensor(sensor), .fault_clr(fault_clr),
    .valve(valve), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model: phase name plus cycles elapsed in it, compared to a duration table.
  localparam int P_IDLE = 0, P_OPEN = 1, P_WAIT = 2, P_PURGE = 3, P_COOL = 4, P_FAULT = 5;
  int dur [6] = '{0, ON, WT, PG, CL, 0};
  int m_ph [CH];
  int m_el [CH];
  int m_rt [CH];

  function automatic void m_enter(int c, int p);
    m_ph[c] = p;
    m_el[c] = 0;
  endfunction

  function automatic bit m_expired(int c);
    m_el[c] = m_el[c] + 1;
    return m_el[c] >= dur[m_ph[c]];
  endfunction

  function automatic void model_step();
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_enter(c, P_IDLE); m_rt[c] = 0;
      end else if (m_ph[c] == P_FAULT) begin
        if (fault_clr[c]) begin m_enter(c, P_IDLE); m_rt[c] = 0; end
      end else if (!en[c]) begin
        m_enter(c, P_IDLE); m_rt[c] = 0;
      end else begin
        case (m_ph[c])
          P_IDLE:  if (sensor[c]) begin m_enter(c, P_OPEN); m_rt[c] = 0; end
          P_OPEN:  if (m_expired(c)) m_enter(c, P_WAIT);
          P_WAIT: begin
            if (sensor[c]) begin
              if (m_rt[c] < MAXRT) begin m_rt[c]++; m_enter(c, P_OPEN); end
              else m_enter(c, P_FAULT);
            end else if (m_expired(c)) m_enter(c, P_PURGE);
          end
          P_PURGE: begin
            if (sensor[c]) m_enter(c, P_WAIT);
            else if (m_expired(c)) m_enter(c, P_COOL);
          end
          P_COOL:  if (m_expired(c)) begin m_enter(c, P_IDLE); m_rt[c] = 0; end
          default: m_enter(c, P_IDLE);
        endcase
      end
    end
  endfunction

  function automatic logic [CH-1:0] m_out(int kind);
    logic [CH-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      case (kind)
        0:       r[c] = (m_ph[c] == P_OPEN) || (m_ph[c] == P_PURGE);
        1:       r[c] = (m_ph[c] != P_IDLE);
        default: r[c] = (m_ph[c] == P_FAULT);
      endcase
    end
    return r;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_valve", 32'(valve), 32'(m_out(0)));
    chk("model_busy",  32'(busy),  32'(m_out(1)));
    chk("model_fault", 32'(fault), 32'(m_out(2)));
  endtask

  task automatic do_reset();
    rst = 1'b1; en = '0; sensor = '0; fault_clr = '0;
    tick();
    rst = 1'b0; en = '1;
  endtask

  // Single-trigger timeline relative to the sensor edge.
  function automatic bit sv_valve(int t);
    return (t >= 0 && t <= 2) || (t >= 7 && t <= 8);
  endfunction
  function automatic bit sv_busy(int t);
    return (t >= 0 && t <= 13);
  endfunction

  typedef struct {
    logic          rst;
    logic [CH-1:0] en, sensor, clr, v, b, f;
  } vec_t;
  vec_t tbl [17];

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 4'hF, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0};
    tbl[3]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
    tbl[4]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
    tbl[5]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[6]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[7]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[8]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[9]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
    tbl[10] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0};
    tbl[11] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[12] = '{1'b0, 4'hF, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
    tbl[13] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[14] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[15] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[16] = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; sensor = tbl[i].sensor; fault_clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_valve", i), 32'(valve), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),  32'(tbl[i].b));
      chk($sformatf("tbl%0d_fault", i), 32'(fault), 32'(tbl[i].f));
    end

    // Reset mid-OPEN, then a fresh full sequence.
    do_reset();
    sensor = 4'b0001; tick();
    chk("rstmid_open", 32'(valve[0]), 32'd1);
    sensor = '0; rst = 1'b1; tick();
    chk("rstmid_valve", 32'(valve), 32'd0);
    chk("rstmid_busy",  32'(busy),  32'd0);
    chk("rstmid_fault", 32'(fault), 32'd0);
    rst = 1'b0; tick();
    chk("rstmid_idle", 32'(busy), 32'd0);
    for (int t = 0; t <= 15; t++) begin
      sensor = (t == 0) ? 4'b0001 : 4'b0000;
      tick();
      chk($sformatf("restart_v%0d", t), 32'(valve), 32'(sv_valve(t)));
      chk($sformatf("restart_b%0d", t), 32'(busy),  32'(sv_busy(t)));
    end

    // Retrigger limit and fault clear.
    do_reset();
    for (int t = 0; t <= 21; t++) begin
      sensor[0]    = (t == 0 || t == 4 || t == 8 || t == 12);
      fault_clr[0] = (t == 20);
      tick();
      chk($sformatf("retrig_v%0d", t), 32'(valve[0]),
          32'((t <= 2) || (t >= 4 && t <= 6) || (t >= 8 && t <= 10)));
      chk($sformatf("retrig_f%0d", t), 32'(fault[0]), 32'(t >= 12 && t < 20));
      chk($sformatf("retrig_b%0d", t), 32'(busy[0]),  32'(t < 20));
    end
    fault_clr = '0;

    // Purge interrupted by a sensor hit.
    do_reset();
    for (int t = 0; t <= 20; t++) begin
      sensor[0] = (t == 0 || t == 8);
      tick();
      chk($sformatf("purge_v%0d", t), 32'(valve[0]),
          32'((t <= 2) || t == 7 || (t >= 12 && t <= 13)));
      chk($sformatf("purge_b%0d", t), 32'(busy[0]), 32'(t <= 18));
    end

    // Enable abort and priority.
    do_reset();
    sensor = 4'b0010; tick();
    chk("abort_open", 32'(valve[1]), 32'd1);
    sensor = '0; en = 4'b1101; tick();
    chk("abort_valve", 32'(valve[1]), 32'd0);
    chk("abort_busy",  32'(busy[1]),  32'd0);
    sensor = 4'b0010; tick();
    chk("en0_sensor_busy", 32'(busy[1]), 32'd0);
    sensor = '0; tick();
    chk("en0_sensor_idle", 32'(busy[1]), 32'd0);
    en = '1;
    for (int t = 0; t <= 12; t++) begin
      sensor[2] = (t % 4 == 0);
      tick();
    end
    chk("fault_set", 32'(fault[2]), 32'd1);
    sensor = '0; en = 4'b1011;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk($sformatf("fault_en0_f%0d", t), 32'(fault[2]), 32'd1);
      chk($sformatf("fault_en0_v%0d", t), 32'(valve[2]), 32'd0);
    end
    en = '1; fault_clr = 4'b0100; sensor = 4'b0100; tick();
    chk("clr_sensor_fault", 32'(fault[2]), 32'd0);
    chk("clr_sensor_busy",  32'(busy[2]),  32'd0);
    fault_clr = '0; sensor = '0; tick();
    chk("clr_then_idle", 32'(busy[2]), 32'd0);

    // Channel independence: ch3 offset by two cycles.
    do_reset();
    for (int t = 0; t <= 17; t++) begin
      sensor = {(t == 2), 2'b00, (t == 0)};
      tick();
      chk($sformatf("indep0_v%0d", t), 32'(valve[0]), 32'(sv_valve(t)));
      chk($sformatf("indep3_v%0d", t), 32'(valve[3]), 32'(sv_valve(t - 2)));
      chk($sformatf("indep3_b%0d", t), 32'(busy[3]),  32'(sv_busy(t - 2)));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < CH; c++) begin
        en[c]        = ($urandom_range(0, 19) != 0);
        sensor[c]    = ($urandom_range(0, 3) == 0);
        fault_clr[c] = ($urandom_range(0, 9) == 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/valve_seq_ctrl.md
Name: valve_seq_ctrl

Overview:
- Multi-channel, parametrised sensor-driven valve sequencer. Successor to the single-channel fixed-timing valve FSM.
- Each channel runs an independent open / wait / purge / cool cycle with programmable durations.
- Adds a per-channel enable, a retrigger limit that latches a fault, and fault clearing.
- Sits between the debounced sensor inputs and the valve driver outputs.

Parameters:
- CHANNELS, 4, number of independent sensor/valve channels (>=1)
- ON_CYCLES, 3, cycles the valve is held open per trigger (>=1)
- WAIT_CYCLES, 4, closed window in which a sensor hit retriggers (>=1)
- PURGE_CYCLES, 2, cycles the valve is open for the purge pulse (>=1)
- COOL_CYCLES, 5, closed lockout before returning to idle (>=1)
- MAX_RETRIG, 2, retriggers allowed per cycle; one more causes a fault (>=0)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- en  in  CHANNELS  per-channel enable
- sensor  in  CHANNELS  per-channel sensor, sampled at clk rise
- fault_clr  in  CHANNELS  per-channel fault clear request
- valve  out  CHANNELS  valve drive, registered
- busy  out  CHANNELS  1 when the channel is not IDLE, registered
- fault  out  CHANNELS  1 while the channel is in FAULT, registered

Behaviour:
- Reset (rst=1 at clk rise): every channel goes to IDLE; timer=0, retrig=0; valve=0, busy=0, fault=0. Reset overrides all other inputs, including mid-sequence.
- Channels are fully independent. Per channel there is a state register, a down-counter timer, and a retrig counter.
- Timer width = clog2(max duration parameter + 1). Retrig width = clog2(MAX_RETRIG + 1), minimum 1.
- Moore outputs, registered with the state: valve=1 only in OPEN and PURGE; busy=1 in any state except IDLE; fault=1 only in FAULT.
- Latency: a sensor sample at edge k produces valve=1 from edge k onward, i.e. one cycle after sensor is presented.
- Timer: loaded with DUR-1 on state entry and decremented each cycle. The state exits at the edge where timer==0, so the state lasts exactly DUR cycles.
- IDLE: sensor=1 and en=1 -> OPEN; timer=ON_CYCLES-1; retrig=0.
- OPEN: sensor ignored. At timer==0 -> WAIT with timer=WAIT_CYCLES-1.
- WAIT:
  - sensor=1 and retrig<MAX_RETRIG -> OPEN; retrig+1; timer reloaded.
  - sensor=1 and retrig==MAX_RETRIG -> FAULT.
  - sensor=0 with timer==0 -> PURGE; timer=PURGE_CYCLES-1.
- PURGE: sensor=1 on any cycle -> WAIT immediately; timer=WAIT_CYCLES-1; retrig unchanged. Otherwise at timer==0 -> COOL; timer=COOL_CYCLES-1.
- COOL: sensor ignored. At timer==0 -> IDLE; retrig cleared.
- FAULT: valve=0, fault=1. Held until fault_clr=1, then -> IDLE, retrig=0. en has no effect on FAULT. A sensor hit in the same cycle as fault_clr is ignored; the channel enters IDLE.
- en=0 in any state other than FAULT -> IDLE at the next edge (abort). valve drops the same edge and retrig is cleared. en=0 beats a simultaneous sensor hit.
- fault_clr outside FAULT has no effect.
- Illegal state encodings recover to IDLE with all outputs 0.

Test Plan:
- Reset mid-OPEN: ch0 triggered, rst=1 one cycle at edge k+1 -> from k+1: valve=0, busy=0, fault=0; a fresh sensor pulse restarts a normal sequence.
- Single trigger, defaults, ch0 sensor=1 sampled at edge k -> valve[0] timeline:
  - 1 for edges k..k+2
  - 0 for k+3..k+6
  - 1 for k+7..k+8
  - 0 for k+9..k+13
  - busy[0]=0 from k+14
  - other channels stay 0
- Retrigger limit: hits at edges k, k+4, k+8, k+12 (each in WAIT) -> hits at k+4 and k+8 reopen (3-cycle pulses); hit at k+12 gives fault[0]=1, valve=0 from k+12. fault_clr at k+20 -> fault=0, busy=0 from k+20.
- Purge interrupt: hit at k with no retriggers, second hit at k+8 (PURGE) -> valve=0 from k+8; WAIT restarts; with no further hits, valve=1 at k+12..k+13.
- Enable abort and priority:
  - en[1]=0 at edge k+1 during OPEN -> valve[1]=0, busy[1]=0 at k+1.
  - en=0 with sensor=1 together -> stays IDLE.
  - In FAULT: en=0 keeps fault=1.
- Channel independence: ch0 and ch3 triggered 2 cycles apart -> identical timelines offset by 2; a fault on ch3 does not disturb ch0.
